// File: rtl/prog_rom_arb_pkg.sv
// Shared types for the program ROM arbiter: debug burst states and read-port owner tags.
package prog_rom_arb_pkg;

  localparam int unsigned ROM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } dbg_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DBG
  } owner_t;

endpackage

// File: rtl/prog_rom_burst_seq.sv
// Debug burst-readback sequencer: walks a wrapping address range one word per granted cycle.
module prog_rom_burst_seq
  import prog_rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_start_addr,
  input  logic [ADDR_W:0]   dbg_len,
  input  logic              dbg_gnt,
  output logic              dbg_req,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_busy,
  output logic              dbg_done
);

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

  dbg_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        // A zero-length request never leaves IDLE, so it produces no BUSY and no DONE.
        if (dbg_start && (dbg_len != '0)) begin
          addr_d  = dbg_start_addr;
          rem_d   = dbg_len;
          state_d = BURST;
        end
      end
      BURST: begin
        if (dbg_gnt) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign dbg_req  = (state_q == BURST);
  assign dbg_addr = addr_q;
  assign dbg_busy = (state_q != IDLE);
  // DRAIN lasts one cycle and always follows the final grant, so it lines up with the last VALID.
  assign dbg_done = (state_q == DRAIN);

endmodule

// File: rtl/prog_rom_arbiter.sv
// Shares the program ROM read port between CPU fetch and the debug burst engine.
// Optional PROG_ARB_PERF_EN adds saturating stall/conflict counters.
module prog_rom_arbiter
  import prog_rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 18,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FETCH_REQ,
  input  logic [ADDR_W-1:0] FETCH_ADDR,
  output logic              FETCH_GNT,
  output logic              FETCH_VALID,
  output logic [DATA_W-1:0] FETCH_IR,
  input  logic              DBG_START,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [ADDR_W:0]   DBG_LEN,
  output logic              DBG_BUSY,
  output logic              DBG_VALID,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic              DBG_DONE,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0] ROM_DATA,
  output logic [15:0]       STALL_CNT,
  output logic [15:0]       CONFLICT_CNT
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic              dbg_req, dbg_gnt, dbg_busy, dbg_done, fetch_gnt, forced;
  logic [ADDR_W-1:0] dbg_addr;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        wait_q, wait_d;
  owner_t            owner_q, owner_d;

  prog_rom_burst_seq #(
    .ADDR_W(ADDR_W)
  ) u_burst_seq (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .dbg_start     (DBG_START),
    .dbg_start_addr(DBG_ADDR),
    .dbg_len       (DBG_LEN),
    .dbg_gnt       (dbg_gnt),
    .dbg_req       (dbg_req),
    .dbg_addr      (dbg_addr),
    .dbg_busy      (dbg_busy),
    .dbg_done      (dbg_done)
  );

  always_comb begin
    forced     = dbg_req && (wait_q == MAX_WAIT_C);
    // Gated by RST_N so a fetch request held through reset cannot show a grant.
    fetch_gnt  = RST_N && FETCH_REQ && !forced;
    dbg_gnt    = dbg_req && !fetch_gnt;
    rom_addr_d = rom_addr_q;
    owner_d    = OWN_NONE;
    if (fetch_gnt) begin
      rom_addr_d = FETCH_ADDR;
      owner_d    = OWN_FETCH;
    end else if (dbg_gnt) begin
      rom_addr_d = dbg_addr;
      owner_d    = OWN_DBG;
    end
    wait_d = wait_q;
    if (!dbg_req || dbg_gnt) begin
      wait_d = '0;
    end else if (wait_q != MAX_WAIT_C) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rom_addr_q <= '0;
      wait_q     <= '0;
      owner_q    <= OWN_NONE;
    end else begin
      rom_addr_q <= rom_addr_d;
      wait_q     <= wait_d;
      owner_q    <= owner_d;
    end
  end

  // The ROM registers its address, so the granted address goes out in the grant cycle.
  assign ROM_ADDR    = rom_addr_d;
  assign FETCH_GNT   = fetch_gnt;
  assign FETCH_VALID = (owner_q == OWN_FETCH);
  assign FETCH_IR    = FETCH_VALID ? ROM_DATA : '0;
  assign DBG_VALID   = (owner_q == OWN_DBG);
  assign DBG_DATA    = DBG_VALID ? ROM_DATA : '0;
  assign DBG_BUSY    = dbg_busy;
  assign DBG_DONE    = dbg_done;

`ifdef PROG_ARB_PERF_EN
  logic [15:0] stall_q, conflict_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q    <= '0;
      conflict_q <= '0;
    end else begin
      if (forced && FETCH_REQ && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (FETCH_REQ && dbg_req && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
    end
  end

  assign STALL_CNT    = stall_q;
  assign CONFLICT_CNT = conflict_q;
`else
  assign STALL_CNT    = '0;
  assign CONFLICT_CNT = '0;
`endif

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Directed bench for prog_rom_arbiter with a registered 1024x18 ROM model (rom[i] = i + 0x100).
module tb_prog_rom_arbiter;
  import prog_rom_arb_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        FETCH_REQ;
  logic [9:0]  FETCH_ADDR;
  logic        FETCH_GNT;
  logic        FETCH_VALID;
  logic [17:0] FETCH_IR;
  logic        DBG_START;
  logic [9:0]  DBG_ADDR;
  logic [10:0] DBG_LEN;
  logic        DBG_BUSY;
  logic        DBG_VALID;
  logic [17:0] DBG_DATA;
  logic        DBG_DONE;
  logic [9:0]  ROM_ADDR;
  logic [17:0] ROM_DATA;
  logic [15:0] STALL_CNT;
  logic [15:0] CONFLICT_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  prog_rom_arbiter #(
    .ADDR_W  (10),
    .DATA_W  (18),
    .MAX_WAIT(8)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FETCH_REQ   (FETCH_REQ),
    .FETCH_ADDR  (FETCH_ADDR),
    .FETCH_GNT   (FETCH_GNT),
    .FETCH_VALID (FETCH_VALID),
    .FETCH_IR    (FETCH_IR),
    .DBG_START   (DBG_START),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_LEN     (DBG_LEN),
    .DBG_BUSY    (DBG_BUSY),
    .DBG_VALID   (DBG_VALID),
    .DBG_DATA    (DBG_DATA),
    .DBG_DONE    (DBG_DONE),
    .ROM_ADDR    (ROM_ADDR),
    .ROM_DATA    (ROM_DATA),
    .STALL_CNT   (STALL_CNT),
    .CONFLICT_CNT(CONFLICT_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous ROM: address sampled on the edge, data one cycle later.
  always @(posedge CLK) ROM_DATA <= 18'(ROM_ADDR) + 18'h100;

  function automatic logic [17:0] rom_val(input logic [9:0] a);
    return 18'(a) + 18'h100;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          n, nv, nd, err;
    logic [17:0] first_d, last_d;
    logic [9:0]  a;

    RST_N = 1'b0; FETCH_REQ = 1'b1; FETCH_ADDR = '0;
    DBG_START = 1'b0; DBG_ADDR = '0; DBG_LEN = '0;
    #2;
    check_eq("rst_fetch_gnt", 32'(FETCH_GNT), 0);
    check_eq("rst_rom_addr", 32'(ROM_ADDR), 0);
    check_eq("rst_busy", 32'(DBG_BUSY), 0);
    check_eq("rst_valids", {30'd0, FETCH_VALID, DBG_VALID}, 0);
    FETCH_REQ = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Fetch only: four back-to-back fetches, data one cycle after each grant.
    for (int i = 0; i < 5; i++) begin
      FETCH_REQ  = (i < 4);
      FETCH_ADDR = 10'(i);
      #1;
      if (i < 4) begin
        check_eq("fetch_gnt", 32'(FETCH_GNT), 1);
        check_eq("fetch_rom_addr", 32'(ROM_ADDR), 32'(i));
      end
      if (i > 0) begin
        check_eq("fetch_valid", 32'(FETCH_VALID), 1);
        check_eq("fetch_ir", 32'(FETCH_IR), 32'(rom_val(10'(i - 1))));
      end
      tick();
    end
    check_eq("fetch_valid_end", 32'(FETCH_VALID), 0);
    check_eq("fetch_ir_end", 32'(FETCH_IR), 0);

    // Debug burst with idle CPU, wrapping 0x3FF -> 0x000.
    DBG_START = 1'b1; DBG_ADDR = 10'h3FE; DBG_LEN = 11'd4;
    tick();
    DBG_START = 1'b0;
    check_eq("dbg_busy", 32'(DBG_BUSY), 1);
    check_eq("dbg_rom_addr", 32'(ROM_ADDR), 32'h3FE);
    tick();
    a = 10'h3FE;
    for (int k = 0; k < 4; k++) begin
      check_eq("dbg_valid", 32'(DBG_VALID), 1);
      check_eq("dbg_data", 32'(DBG_DATA), 32'(rom_val(a)));
      check_eq("dbg_done", 32'(DBG_DONE), (k == 3) ? 1 : 0);
      check_eq("dbg_busy_run", 32'(DBG_BUSY), 1);
      a = a + 10'd1;
      tick();
    end
    check_eq("dbg_busy_fall", 32'(DBG_BUSY), 0);
    check_eq("dbg_valid_end", 32'(DBG_VALID), 0);
    check_eq("dbg_data_end", 32'(DBG_DATA), 0);

    // Starvation: fetch held, debug forced through after 8 lost cycles per word.
    FETCH_REQ = 1'b1; FETCH_ADDR = 10'h010;
    DBG_START = 1'b1; DBG_ADDR = 10'h020; DBG_LEN = 11'd2;
    tick();
    DBG_START = 1'b0;
    n = 0;
    while (FETCH_GNT === 1'b1 && n < 40) begin n++; tick(); end
    check_eq("starve_lost1", 32'(n), 8);
    check_eq("starve_rom_addr1", 32'(ROM_ADDR), 32'h020);
    tick();
    check_eq("starve_valid1", 32'(DBG_VALID), 1);
    check_eq("starve_data1", 32'(DBG_DATA), 32'(rom_val(10'h020)));
    check_eq("starve_fvalid1", 32'(FETCH_VALID), 0);
    n = 0;
    while (FETCH_GNT === 1'b1 && n < 40) begin n++; tick(); end
    check_eq("starve_lost2", 32'(n), 8);
    check_eq("starve_rom_addr2", 32'(ROM_ADDR), 32'h021);
    tick();
    check_eq("starve_data2", 32'(DBG_DATA), 32'(rom_val(10'h021)));
    check_eq("starve_done", 32'(DBG_DONE), 1);
    FETCH_REQ = 1'b0;
    tick();
    check_eq("starve_busy_end", 32'(DBG_BUSY), 0);
`ifdef PROG_ARB_PERF_EN
    check_eq("stall_cnt", 32'(STALL_CNT), 2);
    check_eq("conflict_cnt", 32'(CONFLICT_CNT), 18);
`else
    check_eq("stall_cnt_off", 32'(STALL_CNT), 0);
    check_eq("conflict_cnt_off", 32'(CONFLICT_CNT), 0);
`endif

    // Zero-length start is ignored.
    DBG_START = 1'b1; DBG_ADDR = 10'h005; DBG_LEN = 11'd0;
    tick();
    DBG_START = 1'b0;
    check_eq("len0_busy", 32'(DBG_BUSY), 0);
    tick();
    check_eq("len0_valid", 32'(DBG_VALID), 0);
    check_eq("len0_done", 32'(DBG_DONE), 0);

    // Restart during BURST is ignored; the burst keeps its original length.
    DBG_START = 1'b1; DBG_ADDR = 10'h100; DBG_LEN = 11'd3;
    tick();
    DBG_ADDR = 10'h000; DBG_LEN = 11'd10;
    tick();
    DBG_START = 1'b0;
    nv = 0; nd = 0; first_d = '0; last_d = '0;
    for (int c = 0; c < 20; c++) begin
      if (DBG_VALID) begin
        if (nv == 0) first_d = DBG_DATA;
        nv++;
      end
      if (DBG_DONE) begin nd++; last_d = DBG_DATA; end
      tick();
    end
    check_eq("restart_count", 32'(nv), 3);
    check_eq("restart_done", 32'(nd), 1);
    check_eq("restart_first", 32'(first_d), 32'(rom_val(10'h100)));
    check_eq("restart_last", 32'(last_d), 32'(rom_val(10'h102)));

    // Full-depth burst; a start in the DONE cycle must also be ignored.
    DBG_START = 1'b1; DBG_ADDR = 10'h155; DBG_LEN = 11'(ROM_DEPTH);
    tick();
    DBG_START = 1'b0;
    nv = 0; nd = 0; err = 0; a = 10'h155;
    for (int c = 0; c < 1100; c++) begin
      if (DBG_VALID) begin
        if (DBG_DATA !== rom_val(a)) err++;
        a = a + 10'd1;
        nv++;
      end
      if (DBG_DONE) begin
        nd++;
        if (!DBG_VALID) err++;
        DBG_START = 1'b1; DBG_LEN = 11'd5;
      end
      tick();
      DBG_START = 1'b0;
    end
    check_eq("full_count", 32'(nv), 1024);
    check_eq("full_done", 32'(nd), 1);
    check_eq("full_data_err", 32'(err), 0);
    check_eq("done_restart_busy", 32'(DBG_BUSY), 0);

    // Reset at word 2 of an 8-word burst.
    DBG_START = 1'b1; DBG_ADDR = 10'h040; DBG_LEN = 11'd8;
    tick();
    DBG_START = 1'b0;
    tick(); tick(); tick();
    check_eq("mid_data_w2", 32'(DBG_DATA), 32'(rom_val(10'h042)));
    RST_N = 1'b0; FETCH_REQ = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(DBG_VALID), 0);
    check_eq("mid_rst_data", 32'(DBG_DATA), 0);
    check_eq("mid_rst_busy", 32'(DBG_BUSY), 0);
    check_eq("mid_rst_fgnt", 32'(FETCH_GNT), 0);
    check_eq("mid_rst_rom_addr", 32'(ROM_ADDR), 0);
    tick();
    RST_N = 1'b1; FETCH_REQ = 1'b0;
    #1;
    check_eq("post_rst_rom_addr", 32'(ROM_ADDR), 0);
    check_eq("post_rst_cnt", {STALL_CNT, CONFLICT_CNT}, 0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (DBG_VALID || DBG_BUSY || FETCH_VALID) n++;
    end
    check_eq("post_rst_quiet", 32'(n), 0);
    DBG_START = 1'b1; DBG_ADDR = 10'h3FF; DBG_LEN = 11'd2;
    tick();
    DBG_START = 1'b0;
    tick();
    check_eq("post_rst_data0", 32'(DBG_DATA), 32'(rom_val(10'h3FF)));
    tick();
    check_eq("post_rst_data1", 32'(DBG_DATA), 32'(rom_val(10'h000)));
    check_eq("post_rst_done", 32'(DBG_DONE), 1);
    tick();
    check_eq("post_rst_idle", 32'(DBG_BUSY), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
